// File: rtl/intr_seq.sv
// Interrupt sequencer: synchronizes an external request, latches it as pending, and
// steps the control unit through interrupt entry, service and flag-restoring return.
module intr_seq #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic intr_in,
  input  logic instr_done,
  input  logic sei,
  input  logic cli,
  input  logic retie,
  input  logic retid,
  output logic int_ack,
  output logic flg_shad_ld,
  output logic flg_ld_sel,
  output logic flg_rest_ld,
  output logic i_en,
  output logic in_isr,
  output logic pending
);

  typedef enum logic [1:0] {StRun, StEnter, StIsr, StRestore} state_e;

  localparam logic [2:0] SettleInit = 3'(SYNC_STAGES + 1);

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic [2:0]             settle_q;
  logic                   pending_q, pending_d;
  logic                   i_en_q, i_en_d;
  logic                   ret_en_q, ret_en_d;
  logic                   int_ack_q, flg_shad_ld_q, flg_ld_sel_q, flg_rest_ld_q, in_isr_q;
  logic                   edge_det;

  // Edges are ignored until the synchronizer has refilled after reset, so a level
  // held high through reset release is not mistaken for a rise.
  assign edge_det = (settle_q == 3'd0) && sync_q[SYNC_STAGES-1] && !edge_q;

  always_comb begin
    state_d   = state_q;
    i_en_d    = i_en_q;
    ret_en_d  = ret_en_q;
    pending_d = pending_q;
    unique case (state_q)
      StRun: begin
        if (cli)      i_en_d = 1'b0;
        else if (sei) i_en_d = 1'b1;
        if (pending_q && i_en_q && instr_done) state_d = StEnter;
      end
      StEnter: begin
        i_en_d    = 1'b0;
        pending_d = 1'b0;
        state_d   = StIsr;
      end
      StIsr: begin
        if (cli)      i_en_d = 1'b0;
        else if (sei) i_en_d = 1'b1;
        if (retid) begin
          ret_en_d = 1'b0;
          state_d  = StRestore;
        end else if (retie) begin
          ret_en_d = 1'b1;
          state_d  = StRestore;
        end
      end
      StRestore: begin
        i_en_d  = ret_en_q;
        state_d = StRun;
      end
      default: state_d = StRun;
    endcase
    if (edge_det) pending_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= StRun;
      sync_q        <= '0;
      edge_q        <= 1'b0;
      settle_q      <= SettleInit;
      pending_q     <= 1'b0;
      i_en_q        <= 1'b0;
      ret_en_q      <= 1'b0;
      int_ack_q     <= 1'b0;
      flg_shad_ld_q <= 1'b0;
      flg_ld_sel_q  <= 1'b0;
      flg_rest_ld_q <= 1'b0;
      in_isr_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync_q        <= {sync_q[SYNC_STAGES-2:0], intr_in};
      edge_q        <= sync_q[SYNC_STAGES-1];
      settle_q      <= (settle_q == 3'd0) ? 3'd0 : settle_q - 3'd1;
      pending_q     <= pending_d;
      i_en_q        <= i_en_d;
      ret_en_q      <= ret_en_d;
      // Strobes are registered from the next state so they are clean Moore outputs.
      int_ack_q     <= (state_d == StEnter);
      flg_shad_ld_q <= (state_d == StEnter);
      flg_ld_sel_q  <= (state_d == StRestore);
      flg_rest_ld_q <= (state_d == StRestore);
      in_isr_q      <= (state_d == StIsr);
    end
  end

  assign int_ack     = int_ack_q;
  assign flg_shad_ld = flg_shad_ld_q;
  assign flg_ld_sel  = flg_ld_sel_q;
  assign flg_rest_ld = flg_rest_ld_q;
  assign in_isr      = in_isr_q;
  assign i_en        = i_en_q;
  assign pending     = pending_q;

endmodule
